border_box_reader: RTL and testbench
====================================

// Module: border_box_reader
// PURPOSE
//  Reads the column/row border RAMs filled by the projection stage once a projection completes.
//  Caches up to NUM_COL x NUM_ROW digit bounding boxes in registers.
//  Per incoming pixel, outputs whether it lies inside a digit box, which box, and whether it
//  sits on the box outline. Feeds the feature extractor and the LCD box overlay.
// PARAMETERS
//  NUM_COL  4    max digits per row; col table depth 2*NUM_COL
//  NUM_ROW  1    max digit rows; row table depth 2*NUM_ROW
//  DEPBIT   12   border RAM address/data width
// PORTS
//  clk                 in   1       pixel clock
//  rst_n               in   1       reset, asynchronous, active-low
//  project_done_flag   in   1       high while projection results are stable
//  num_col             in   4       digit columns found
//  num_row             in   4       digit rows found
//  col_border_addr_rd  out  DEPBIT  column border RAM read address
//  col_border_data_rd  in   DEPBIT  column border RAM read data, 1-cycle latency
//  row_border_addr_rd  out  DEPBIT  row border RAM read address
//  row_border_data_rd  in   DEPBIT  row border RAM read data, 1-cycle latency
//  h_total_pexel       in   11      active width (used by clamp option)
//  v_total_pexel       in   11      active height (used by clamp option)
//  frame_de            in   1       pixel data enable
//  xpos, ypos          in   11 ea   current pixel coordinate
//  box_valid           out  1       box table loaded and usable
//  in_digit            out  1       pixel inside some box (inclusive edges)
//  on_outline          out  1       pixel on an edge of that box
//  col_idx, row_idx    out  4 ea    box index of the pixel; 0 when in_digit=0
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; box table cleared.
//  RAM layout (fixed): digit k left edge at addr 2k+1, right edge at 2k+2; rows identical.
//  Effective counts: nc = min(num_col, NUM_COL), nr = min(num_row, NUM_ROW), sampled on start.
//  Start = rising edge of project_done_flag (registered edge detect).
//  FSM:
//   IDLE      -> FETCH_COL on start; box_valid <= 0.
//   FETCH_COL issues addrs 1..2*nc on consecutive cycles; data captured one cycle after each address.
//             -> FETCH_ROW one cycle after the last capture. nc=0: skip directly to FETCH_ROW.
//   FETCH_ROW same over 1..2*nr on the row RAM.
//             -> READY after the last capture. nr=0: skip to READY.
//   READY     box_valid=1. A new start -> FETCH_COL, box_valid drops the next cycle.
//  Fetch time is 2*nc + 2*nr + 2 cycles max.
//  Both addr outputs are 0 when not fetching.
//  A start during FETCH_* is ignored.
//  Pixel path is registered, 1-cycle latency from frame_de/xpos/ypos to in_digit/on_outline/idx:
//   hit(c,r) = frame_de & box_valid & c<nc & r<nr & L[c]<=x<=R[c] & T[r]<=y<=B[r]
//   Lowest (r,c) wins if boxes overlap (r first, then c).
//   on_outline = hit & (x==L | x==R | y==T | y==B).
//   Outputs are 0 when frame_de=0 or box_valid=0.
//  Entries with L>R or T>B never hit; no error is flagged.
//  Reset mid-fetch returns to IDLE with the table cleared; no partial table becomes valid.
// CONFIGURATION
//  BORDER_CLAMP_EN defined:
//   Each captured value whose top bit is set (underflow from edge-2) is replaced by 0.
//   Each captured right/bottom value >= h_total_pexel/v_total_pexel is replaced by total-1.
//   Clamping is applied at capture; adds no latency.
//  BORDER_CLAMP_EN undefined: values are stored raw; an underflowed left/top edge makes that box
//   never hit.
// TESTING
//  1. Col RAM {1:10,2:40,3:60,4:90}, row {1:20,2:80}, num_col=2, num_row=1, done 0->1
//     -> col addrs 1,2,3,4 then row addrs 1,2; box_valid=1 after 8 cycles.
//  2. Same table; pixel (10,20) -> in_digit=1, on_outline=1, col_idx=0.
//     Pixel (75,50) -> in_digit=1, outline=0, col_idx=1.
//     Pixel (50,50) -> in_digit=0. Each result 1 cycle after input.
//  3. num_col=9 with NUM_COL=4 -> only addrs 1..8 read; col_idx never exceeds 3.
//  4. num_col=0 -> no col reads, box_valid=1, in_digit always 0.
//     Second done edge in READY -> box_valid=0 next cycle, refetch.
//  5. Left edge 0x7FE (underflow), h_total_pexel=480, right edge 500:
//     CLAMP_EN stores 0 and 479, so pixel (0,y) hits.
//     Without CLAMP_EN, that box never hits.
//  6. rst_n low mid-FETCH_COL -> all outputs 0 immediately.
//     After release, box_valid stays 0 until a new done edge completes a full fetch.

Source files
------------

// File: rtl/border_box_reader.sv
// border_box_reader: loads the digit bounding-box table from the column/row
// border RAMs after a projection completes, then classifies each incoming
// pixel against the cached boxes (inside / outline / box index).
// Build option: BORDER_CLAMP_EN clamps captured edges (underflow -> 0,
// right/bottom edges beyond the active area -> total-1).
//
// state       | meaning
// ------------+------------------------------------------------------------
// S_IDLE      | no table loaded since reset; waiting for a done edge
// S_FETCH_COL | issuing column RAM addresses 1..2*nc
// S_FETCH_ROW | issuing row RAM addresses 1..2*nr
// S_DRAIN     | last read still in flight; captured on leaving this state
// S_READY     | table valid, pixel classification enabled
module border_box_reader #(
  parameter int NUM_COL = 4,
  parameter int NUM_ROW = 1,
  parameter int DEPBIT  = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              project_done_flag,
  input  logic [3:0]        num_col,
  input  logic [3:0]        num_row,
  output logic [DEPBIT-1:0] col_border_addr_rd,
  input  logic [DEPBIT-1:0] col_border_data_rd,
  output logic [DEPBIT-1:0] row_border_addr_rd,
  input  logic [DEPBIT-1:0] row_border_data_rd,
  input  logic [10:0]       h_total_pexel,
  input  logic [10:0]       v_total_pexel,
  input  logic              frame_de,
  input  logic [10:0]       xpos,
  input  logic [10:0]       ypos,
  output logic              box_valid,
  output logic              in_digit,
  output logic              on_outline,
  output logic [3:0]        col_idx,
  output logic [3:0]        row_idx
);

  // Pixel coordinate width; edges are compared in the wider RAM data domain.
  localparam int CW = 11;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH_COL = 3'd1;
  localparam logic [2:0] S_FETCH_ROW = 3'd2;
  localparam logic [2:0] S_DRAIN     = 3'd3;
  localparam logic [2:0] S_READY     = 3'd4;

  localparam logic [3:0] NC_MAX = 4'(NUM_COL);
  localparam logic [3:0] NR_MAX = 4'(NUM_ROW);

  logic              done_q;
  logic              start;
  logic [2:0]        state_q, state_d;
  logic [DEPBIT-1:0] addr_q, addr_d;
  logic [3:0]        nc_q, nc_d, nr_q, nr_d;
  logic [3:0]        nc_clip, nr_clip;
  logic [DEPBIT-1:0] col_last, row_last;

  // One read in flight: describes the address the RAM sampled on the last edge,
  // so the RAM data output currently belongs to it.
  logic              iss_vld_q;
  logic              iss_row_q;
  logic [DEPBIT-1:0] iss_addr_q;

  logic [DEPBIT-1:0] cap_raw;
  logic [10:0]       cap_total;
  logic [DEPBIT-1:0] cap_lo;
  logic [DEPBIT-1:0] cap_hi;

  logic [DEPBIT-1:0] col_l_q [NUM_COL];
  logic [DEPBIT-1:0] col_r_q [NUM_COL];
  logic [DEPBIT-1:0] row_t_q [NUM_ROW];
  logic [DEPBIT-1:0] row_b_q [NUM_ROW];

  logic [DEPBIT-1:0] x_ext, y_ext;
  logic              hit_d, outl_d;
  logic [3:0]        ci_d, ri_d;
  logic              in_digit_q, on_outline_q;
  logic [3:0]        col_idx_q, row_idx_q;

  assign start    = project_done_flag & ~done_q;
  assign nc_clip  = (num_col > NC_MAX) ? NC_MAX : num_col;
  assign nr_clip  = (num_row > NR_MAX) ? NR_MAX : num_row;
  assign col_last = DEPBIT'({nc_q, 1'b0});
  assign row_last = DEPBIT'({nr_q, 1'b0});

  assign box_valid          = (state_q == S_READY);
  assign col_border_addr_rd = (state_q == S_FETCH_COL) ? addr_q : '0;
  assign row_border_addr_rd = (state_q == S_FETCH_ROW) ? addr_q : '0;

  // Previous done level for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done_q <= 1'b0;
    else        done_q <= project_done_flag;
  end

  // Fetch sequencer: next state, address counter and latched counts.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    nc_d    = nc_q;
    nr_d    = nr_q;
    case (state_q)
      S_IDLE, S_READY: begin
        if (start) begin
          nc_d   = nc_clip;
          nr_d   = nr_clip;
          addr_d = DEPBIT'(1);
          if (nc_clip != 4'd0)      state_d = S_FETCH_COL;
          else if (nr_clip != 4'd0) state_d = S_FETCH_ROW;
          else                      state_d = S_DRAIN;
        end
      end
      S_FETCH_COL: begin
        if (addr_q == col_last) begin
          if (nr_q != 4'd0) begin
            state_d = S_FETCH_ROW;
            addr_d  = DEPBIT'(1);
          end else begin
            state_d = S_DRAIN;
            addr_d  = '0;
          end
        end else begin
          addr_d = addr_q + DEPBIT'(1);
        end
      end
      S_FETCH_ROW: begin
        if (addr_q == row_last) begin
          state_d = S_DRAIN;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + DEPBIT'(1);
        end
      end
      S_DRAIN: begin
        state_d = S_READY;
        addr_d  = '0;
      end
      default: begin
        state_d = S_IDLE;
        addr_d  = '0;
      end
    endcase
  end

  // Sequencer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      nc_q    <= 4'd0;
      nr_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      nc_q    <= nc_d;
      nr_q    <= nr_d;
    end
  end

  // Track which address the RAM is answering this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_vld_q  <= 1'b0;
      iss_row_q  <= 1'b0;
      iss_addr_q <= '0;
    end else begin
      iss_vld_q  <= (state_q == S_FETCH_COL) || (state_q == S_FETCH_ROW);
      iss_row_q  <= (state_q == S_FETCH_ROW);
      iss_addr_q <= addr_q;
    end
  end

  assign cap_raw   = iss_row_q ? row_border_data_rd : col_border_data_rd;
  assign cap_total = iss_row_q ? v_total_pexel : h_total_pexel;

`ifdef BORDER_CLAMP_EN
  // Clamp captured edges: any bit at or above the coordinate MSB means the
  // projection stage underflowed (edge-2 below zero); far edges are limited
  // to the last active pixel.
  always_comb begin
    cap_lo = cap_raw;
    if (|cap_raw[DEPBIT-1:CW-1]) cap_lo = '0;
    cap_hi = cap_lo;
    if ((cap_total != 11'd0) && (cap_lo >= DEPBIT'(cap_total)))
      cap_hi = DEPBIT'(cap_total) - DEPBIT'(1);
  end
`else
  // Raw storage; an underflowed near edge ends up greater than its far edge
  // and the box simply never hits.
  logic unused_totals;
  assign unused_totals = ^cap_total;
  assign cap_lo = cap_raw;
  assign cap_hi = cap_raw;
`endif

  // Box table: odd address = left/top edge, even address = right/bottom edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_COL; i++) begin
        col_l_q[i] <= '0;
        col_r_q[i] <= '0;
      end
      for (int j = 0; j < NUM_ROW; j++) begin
        row_t_q[j] <= '0;
        row_b_q[j] <= '0;
      end
    end else if (iss_vld_q) begin
      if (!iss_row_q) begin
        for (int i = 0; i < NUM_COL; i++) begin
          if (iss_addr_q == DEPBIT'(2*i + 1)) col_l_q[i] <= cap_lo;
          if (iss_addr_q == DEPBIT'(2*i + 2)) col_r_q[i] <= cap_hi;
        end
      end else begin
        for (int j = 0; j < NUM_ROW; j++) begin
          if (iss_addr_q == DEPBIT'(2*j + 1)) row_t_q[j] <= cap_lo;
          if (iss_addr_q == DEPBIT'(2*j + 2)) row_b_q[j] <= cap_hi;
        end
      end
    end
  end

  assign x_ext = DEPBIT'(xpos);
  assign y_ext = DEPBIT'(ypos);

  // Box lookup; scanning rows then columns in ascending order gives the
  // lowest (row, col) priority on overlap.
  always_comb begin
    hit_d  = 1'b0;
    outl_d = 1'b0;
    ci_d   = 4'd0;
    ri_d   = 4'd0;
    if (frame_de && box_valid) begin
      for (int r = 0; r < NUM_ROW; r++) begin
        for (int c = 0; c < NUM_COL; c++) begin
          if (!hit_d && (4'(r) < nr_q) && (4'(c) < nc_q) &&
              (col_l_q[c] <= x_ext) && (x_ext <= col_r_q[c]) &&
              (row_t_q[r] <= y_ext) && (y_ext <= row_b_q[r])) begin
            hit_d  = 1'b1;
            outl_d = (x_ext == col_l_q[c]) || (x_ext == col_r_q[c]) ||
                     (y_ext == row_t_q[r]) || (y_ext == row_b_q[r]);
            ci_d   = 4'(c);
            ri_d   = 4'(r);
          end
        end
      end
    end
  end

  // Register the classification result (one pixel clock of latency).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_digit_q   <= 1'b0;
      on_outline_q <= 1'b0;
      col_idx_q    <= 4'd0;
      row_idx_q    <= 4'd0;
    end else begin
      in_digit_q   <= hit_d;
      on_outline_q <= outl_d;
      col_idx_q    <= ci_d;
      row_idx_q    <= ri_d;
    end
  end

  assign in_digit   = in_digit_q;
  assign on_outline = on_outline_q;
  assign col_idx    = col_idx_q;
  assign row_idx    = row_idx_q;

endmodule

// File: tb/tb_border_box_reader.sv
// Directed bench for border_box_reader: border RAM models, address monitor
// and a pixel-result scoreboard.
module tb_border_box_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        project_done_flag;
  logic [3:0]  num_col, num_row;
  logic [11:0] col_border_addr_rd, col_border_data_rd;
  logic [11:0] row_border_addr_rd, row_border_data_rd;
  logic [10:0] h_total_pexel, v_total_pexel;
  logic        frame_de;
  logic [10:0] xpos, ypos;
  logic        box_valid, in_digit, on_outline;
  logic [3:0]  col_idx, row_idx;

  int n_tests = 0;
  int n_fail  = 0;

  logic [11:0] col_mem [16];
  logic [11:0] row_mem [16];
  int          col_seen [$];
  int          row_seen [$];
  logic [9:0]  exp_q [$];

  border_box_reader #(.NUM_COL(4), .NUM_ROW(1), .DEPBIT(12)) dut (
    .clk(clk), .rst_n(rst_n), .project_done_flag(project_done_flag),
    .num_col(num_col), .num_row(num_row),
    .col_border_addr_rd(col_border_addr_rd), .col_border_data_rd(col_border_data_rd),
    .row_border_addr_rd(row_border_addr_rd), .row_border_data_rd(row_border_data_rd),
    .h_total_pexel(h_total_pexel), .v_total_pexel(v_total_pexel),
    .frame_de(frame_de), .xpos(xpos), .ypos(ypos),
    .box_valid(box_valid), .in_digit(in_digit), .on_outline(on_outline),
    .col_idx(col_idx), .row_idx(row_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    col_border_data_rd <= col_mem[col_border_addr_rd[3:0]];
    row_border_data_rd <= row_mem[row_border_addr_rd[3:0]];
  end

  always @(negedge clk) begin
    if (col_border_addr_rd != 12'd0) col_seen.push_back(int'(col_border_addr_rd));
    if (row_border_addr_rd != 12'd0) row_seen.push_back(int'(row_border_addr_rd));
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input int ncol, input int nrow);
    int nce, nre, cnt;
    logic first_bv;
    nce = (ncol > 4) ? 4 : ncol;
    nre = (nrow > 1) ? 1 : nrow;
    col_seen.delete();
    row_seen.delete();
    @(negedge clk);
    num_col = 4'(ncol);
    num_row = 4'(nrow);
    project_done_flag = 1'b1;
    cnt = 0;
    first_bv = 1'b1;
    do begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) first_bv = box_valid;
    end while (!box_valid && cnt < 40);
    check("bv_low_after_start", first_bv, 0);
    check("fetch_cycles", cnt, 2*nce + 2*nre + 2);
    check("box_valid", box_valid, 1);
    check("col_reads", col_seen.size(), 2*nce);
    for (int i = 0; i < 2*nce; i++)
      check("col_addr", (i < col_seen.size()) ? col_seen[i] : -1, i + 1);
    check("row_reads", row_seen.size(), 2*nre);
    for (int i = 0; i < 2*nre; i++)
      check("row_addr", (i < row_seen.size()) ? row_seen[i] : -1, i + 1);
    project_done_flag = 1'b0;
  endtask

  task automatic pix(input string tag, input int x, input int y, input logic de,
                     input logic ind, input logic outl, input int ci, input int ri);
    @(negedge clk);
    xpos = 11'(x);
    ypos = 11'(y);
    frame_de = de;
    exp_q.push_back({ind, outl, 4'(ci), 4'(ri)});
    @(negedge clk);
    check(tag, {in_digit, on_outline, col_idx, row_idx}, exp_q.pop_front());
    frame_de = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_bv"},   box_valid, 0);
    check({tag, "_cadr"}, col_border_addr_rd, 0);
    check({tag, "_radr"}, row_border_addr_rd, 0);
    check({tag, "_pix"},  {in_digit, on_outline, col_idx, row_idx}, 0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      col_mem[i] = 12'd0;
      row_mem[i] = 12'd0;
    end
    col_mem[1] = 12'd10;  col_mem[2] = 12'd40;
    col_mem[3] = 12'd60;  col_mem[4] = 12'd90;
    col_mem[5] = 12'd100; col_mem[6] = 12'd120;
    col_mem[7] = 12'd130; col_mem[8] = 12'd150;
    row_mem[1] = 12'd20;  row_mem[2] = 12'd80;
    rst_n = 1'b0;
    project_done_flag = 1'b0;
    num_col = 4'd0;
    num_row = 4'd0;
    h_total_pexel = 11'd480;
    v_total_pexel = 11'd480;
    frame_de = 1'b1;
    xpos = 11'd10;
    ypos = 11'd20;

    // reset state
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    frame_de = 1'b0;

    // load 2x1 table, then classify pixels
    fetch(2, 1);
    pix("pix_corner",   10, 20, 1'b1, 1'b1, 1'b1, 0, 0);
    pix("pix_inner",    75, 50, 1'b1, 1'b1, 1'b0, 1, 0);
    pix("pix_gap",      50, 50, 1'b1, 1'b0, 1'b0, 0, 0);
    pix("pix_br",       40, 80, 1'b1, 1'b1, 1'b1, 0, 0);
    pix("pix_below",    60, 81, 1'b1, 1'b0, 1'b0, 0, 0);
    pix("pix_de_low",   75, 50, 1'b0, 1'b0, 1'b0, 0, 0);
    pix("pix_masked_c", 140, 50, 1'b1, 1'b0, 1'b0, 0, 0);

    // counts above the table size are clipped
    fetch(9, 5);
    pix("pix_col3",      140, 50, 1'b1, 1'b1, 1'b0, 3, 0);
    pix("pix_col3_edge", 150, 80, 1'b1, 1'b1, 1'b1, 3, 0);
    pix("pix_gap23",     125, 50, 1'b1, 1'b0, 1'b0, 0, 0);
    pix("pix_col2_tl",   100, 20, 1'b1, 1'b1, 1'b1, 2, 0);

    // no columns: table valid but nothing hits; a later edge refetches
    fetch(0, 1);
    pix("pix_nc0_a", 15, 50, 1'b1, 1'b0, 1'b0, 0, 0);
    pix("pix_nc0_b", 75, 50, 1'b1, 1'b0, 1'b0, 0, 0);

    // underflowed left edge and right edge beyond the active width
    col_mem[1] = 12'h7FE;
    col_mem[2] = 12'd500;
    fetch(1, 1);
`ifdef BORDER_CLAMP_EN
    pix("clamp_left",  0,   50, 1'b1, 1'b1, 1'b1, 0, 0);
    pix("clamp_right", 479, 50, 1'b1, 1'b1, 1'b1, 0, 0);
    pix("clamp_out",   480, 50, 1'b1, 1'b0, 1'b0, 0, 0);
`else
    pix("raw_left",  0,   50, 1'b1, 1'b0, 1'b0, 0, 0);
    pix("raw_mid",   200, 50, 1'b1, 1'b0, 1'b0, 0, 0);
    pix("raw_right", 479, 50, 1'b1, 1'b0, 1'b0, 0, 0);
`endif
    col_mem[1] = 12'd10;
    col_mem[2] = 12'd40;

    // reset in the middle of a column fetch
    @(negedge clk);
    num_col = 4'd4;
    num_row = 4'd1;
    project_done_flag = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("mid_fetch_addr", col_border_addr_rd, 2);
    #2;
    rst_n = 1'b0;
    project_done_flag = 1'b0;
    #1;
    check_all_zero("async_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("bv_after_rst", box_valid, 0);
    pix("pix_after_rst", 75, 50, 1'b1, 1'b0, 1'b0, 0, 0);
    fetch(2, 1);
    pix("pix_refetched", 75, 50, 1'b1, 1'b1, 1'b0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
